// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Arbitrates a single shared RAM command port between an SPI-side requester
// and a host-side requester. Once granted, a requester keeps the port across
// address commands (00 / 10) and releases it after a write-data command (01)
// or after the read data for a read-data command (11) has come back.
// Simultaneous requests from IDLE are resolved round-robin, and the SPI side
// wins the first tie after reset.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When the macro is defined, a lock that makes no progress for LOCK_TIMEOUT
//   cycles is released by force. err_timeout pulses for one cycle on release.
//   When the macro is undefined, a lock is held indefinitely and err_timeout
//   is tied low.
module ram_port_arbiter #(
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    // SPI-side requester
    input  logic [9:0] spi_din,
    input  logic       spi_valid,
    output logic       spi_ready,
    output logic [7:0] spi_dout,
    output logic       spi_dout_valid,
    // host-side requester
    input  logic [9:0] hst_din,
    input  logic       hst_valid,
    output logic       hst_ready,
    output logic [7:0] hst_dout,
    output logic       hst_dout_valid,
    // shared RAM port
    output logic [9:0] ram_din,
    output logic       ram_rx_valid,
    input  logic [7:0] ram_dout,
    input  logic       ram_tx_valid,
    // forced lock release indication
    output logic       err_timeout
);

    // Command codes carried in din[9:8]
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        OWN_SPI = 2'b01,
        OWN_HST = 2'b10,
        WAIT_RD = 2'b11
    } state_t;

    // Extracts the command code from a requester word.
    function automatic logic [1:0] f_cmd(input logic [9:0] din);
        return din[9:8];
    endfunction

    // Address commands keep the lock; data commands end the grant.
    function automatic logic f_is_addr_cmd(input logic [1:0] cmd);
        return (cmd == CMD_WR_ADDR) || (cmd == CMD_RD_ADDR);
    endfunction

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_last_hst;         // 1: host was granted most recently
    logic       w_last_hst_nxt;
    logic       r_rd_owner_hst;     // 1: pending read belongs to host
    logic       w_rd_owner_hst_nxt;

    logic       w_spi_hs;
    logic       w_hst_hs;
    logic       w_fwd;
    logic [9:0] w_fwd_din;
    logic       w_ret_spi;
    logic       w_ret_hst;
    logic       w_tmo_fire;

    logic [9:0] r_ram_din;
    logic       r_ram_rx_valid;
    logic [7:0] r_spi_dout;
    logic       r_spi_dout_valid;
    logic [7:0] r_hst_dout;
    logic       r_hst_dout_valid;

    // Ready depends only on the state, so both sides can never be ready together.
    assign spi_ready = (r_state == OWN_SPI);
    assign hst_ready = (r_state == OWN_HST);
    assign w_spi_hs  = spi_valid & spi_ready;
    assign w_hst_hs  = hst_valid & hst_ready;

    assign ram_din        = r_ram_din;
    assign ram_rx_valid   = r_ram_rx_valid;
    assign spi_dout       = r_spi_dout;
    assign spi_dout_valid = r_spi_dout_valid;
    assign hst_dout       = r_hst_dout;
    assign hst_dout_valid = r_hst_dout_valid;

    // State, round-robin pointer and read-owner registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_last_hst     <= 1'b1;
            r_rd_owner_hst <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_last_hst     <= w_last_hst_nxt;
            r_rd_owner_hst <= w_rd_owner_hst_nxt;
        end
    end

    // Next-state decode, grant selection, forwarding and read-return steering.
    always_comb begin
        w_state_nxt        = r_state;
        w_last_hst_nxt     = r_last_hst;
        w_rd_owner_hst_nxt = r_rd_owner_hst;
        w_fwd              = 1'b0;
        w_fwd_din          = 10'd0;
        w_ret_spi          = 1'b0;
        w_ret_hst          = 1'b0;
        case (r_state)
            IDLE: begin
                if (spi_valid && !hst_valid) begin
                    w_state_nxt    = OWN_SPI;
                    w_last_hst_nxt = 1'b0;
                end else if (!spi_valid && hst_valid) begin
                    w_state_nxt    = OWN_HST;
                    w_last_hst_nxt = 1'b1;
                end else if (spi_valid && hst_valid) begin
                    // Tie goes to whichever side was not granted last.
                    if (r_last_hst) begin
                        w_state_nxt    = OWN_SPI;
                        w_last_hst_nxt = 1'b0;
                    end else begin
                        w_state_nxt    = OWN_HST;
                        w_last_hst_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            OWN_SPI: begin
                if (w_spi_hs) begin
                    w_fwd     = 1'b1;
                    w_fwd_din = spi_din;
                    if (f_cmd(spi_din) == CMD_WR_DATA) begin
                        w_state_nxt = IDLE;
                    end else if (f_cmd(spi_din) == CMD_RD_DATA) begin
                        w_state_nxt        = WAIT_RD;
                        w_rd_owner_hst_nxt = 1'b0;
                    end else if (f_is_addr_cmd(f_cmd(spi_din))) begin
                        w_state_nxt = OWN_SPI;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_tmo_fire) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = OWN_SPI;
                end
            end
            OWN_HST: begin
                if (w_hst_hs) begin
                    w_fwd     = 1'b1;
                    w_fwd_din = hst_din;
                    if (f_cmd(hst_din) == CMD_WR_DATA) begin
                        w_state_nxt = IDLE;
                    end else if (f_cmd(hst_din) == CMD_RD_DATA) begin
                        w_state_nxt        = WAIT_RD;
                        w_rd_owner_hst_nxt = 1'b1;
                    end else if (f_is_addr_cmd(f_cmd(hst_din))) begin
                        w_state_nxt = OWN_HST;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_tmo_fire) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = OWN_HST;
                end
            end
            WAIT_RD: begin
                // A returning read wins over a timeout in the same cycle.
                if (ram_tx_valid) begin
                    w_state_nxt = IDLE;
                    if (r_rd_owner_hst) begin
                        w_ret_hst = 1'b1;
                    end else begin
                        w_ret_spi = 1'b1;
                    end
                end else if (w_tmo_fire) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = WAIT_RD;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // RAM command forwarding, one cycle after the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_din      <= 10'd0;
            r_ram_rx_valid <= 1'b0;
        end else begin
            r_ram_rx_valid <= w_fwd;
            if (w_fwd) begin
                r_ram_din <= w_fwd_din;
            end else begin
                r_ram_din <= r_ram_din;
            end
        end
    end

    // Read-data return to the recorded owner; data holds until the next return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spi_dout       <= 8'd0;
            r_spi_dout_valid <= 1'b0;
            r_hst_dout       <= 8'd0;
            r_hst_dout_valid <= 1'b0;
        end else begin
            r_spi_dout_valid <= w_ret_spi;
            r_hst_dout_valid <= w_ret_hst;
            if (w_ret_spi) begin
                r_spi_dout <= ram_dout;
            end else begin
                r_spi_dout <= r_spi_dout;
            end
            if (w_ret_hst) begin
                r_hst_dout <= ram_dout;
            end else begin
                r_hst_dout <= r_hst_dout;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int TMO_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             w_tmo_count;
    logic             r_err_timeout;

    // A cycle counts as stalled when the owner makes no handshake or a read is outstanding.
    always_comb begin
        w_tmo_count = 1'b0;
        case (r_state)
            OWN_SPI: w_tmo_count = !w_spi_hs;
            OWN_HST: w_tmo_count = !w_hst_hs;
            WAIT_RD: w_tmo_count = !ram_tx_valid;
            default: w_tmo_count = 1'b0;
        endcase
    end

    // The LOCK_TIMEOUT-th consecutive stalled cycle forces the release.
    assign w_tmo_fire = w_tmo_count && (r_tmo_cnt == TMO_LAST);

    // Stall counter; any progress, state change or forced release clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
        end else if (w_tmo_count && !w_tmo_fire) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    // One-cycle error pulse that accompanies a forced release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_timeout <= 1'b0;
        end else begin
            r_err_timeout <= w_tmo_fire;
        end
    end

    assign err_timeout = r_err_timeout;
`else
    // Without the timeout feature the lock is never broken.
    logic w_unused_cfg;
    assign w_unused_cfg = (LOCK_TIMEOUT > 0);
    assign w_tmo_fire   = 1'b0;
    assign err_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a per-cycle vector table with expected ready
// levels, plus scoreboard queues for RAM-side commands and returned read data,
// followed by hand-written lock-hold/timeout and reset-during-read sequences.
module tb_ram_port_arbiter;

    logic       clk;
    logic       rst_n;
    logic [9:0] spi_din;
    logic       spi_valid;
    logic       spi_ready;
    logic [7:0] spi_dout;
    logic       spi_dout_valid;
    logic [9:0] hst_din;
    logic       hst_valid;
    logic       hst_ready;
    logic [7:0] hst_dout;
    logic       hst_dout_valid;
    logic [9:0] ram_din;
    logic       ram_rx_valid;
    logic [7:0] ram_dout;
    logic       ram_tx_valid;
    logic       err_timeout;

    int n_tests;
    int n_fail;

    logic [9:0] ram_q[$];   // expected RAM command words
    logic [8:0] ret_q[$];   // expected returns: {1=host/0=spi, data}

    typedef struct {
        logic       sv;
        logic [9:0] sd;
        logic       hv;
        logic [9:0] hd;
        logic       tv;
        logic [7:0] rd;
        logic       esr;
        logic       ehr;
        logic [1:0] eret;   // 0 none, 1 spi, 2 host
    } vec_t;

    localparam int NV = 22;
    vec_t tbl[NV];

    ram_port_arbiter #(.LOCK_TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .spi_din(spi_din), .spi_valid(spi_valid), .spi_ready(spi_ready),
        .spi_dout(spi_dout), .spi_dout_valid(spi_dout_valid),
        .hst_din(hst_din), .hst_valid(hst_valid), .hst_ready(hst_ready),
        .hst_dout(hst_dout), .hst_dout_valid(hst_dout_valid),
        .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
        .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid),
        .err_timeout(err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic sv, input logic [9:0] sd,
                                input logic hv, input logic [9:0] hd,
                                input logic tv, input logic [7:0] rd,
                                input logic esr, input logic ehr,
                                input logic [1:0] eret);
        vec_t v;
        v.sv = sv; v.sd = sd; v.hv = hv; v.hd = hd; v.tv = tv; v.rd = rd;
        v.esr = esr; v.ehr = ehr; v.eret = eret;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard: everything expected before an edge must appear right after it.
    task automatic mon();
        logic [9:0] e;
        logic [8:0] r;
        if (ram_rx_valid) begin
            if (ram_q.size() == 0) begin
                fail_now("ram_unexpected", 32'(ram_din), 32'h0);
            end else begin
                e = ram_q.pop_front();
                check("ram_din", 32'(ram_din), 32'(e));
            end
        end else if (ram_q.size() != 0) begin
            fail_now("ram_missing", 32'(ram_rx_valid), 32'h1);
            ram_q.delete();
        end
        if (spi_dout_valid && hst_dout_valid) begin
            fail_now("ret_both_valid", 32'h3, 32'h1);
        end
        if (spi_dout_valid || hst_dout_valid) begin
            if (ret_q.size() == 0) begin
                fail_now("ret_unexpected", {30'd0, hst_dout_valid, spi_dout_valid}, 32'h0);
            end else begin
                r = ret_q.pop_front();
                check("ret_side", {31'd0, hst_dout_valid}, {31'd0, r[8]});
                check("ret_data", 32'(r[8] ? hst_dout : spi_dout), 32'(r[7:0]));
            end
        end else if (ret_q.size() != 0) begin
            fail_now("ret_missing", 32'h0, 32'h1);
            ret_q.delete();
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        mon();
    endtask

    task automatic drive(input logic sv, input logic [9:0] sd, input logic hv,
                         input logic [9:0] hd, input logic tv, input logic [7:0] rd);
        spi_valid = sv; spi_din = sd; hst_valid = hv; hst_din = hd;
        ram_tx_valid = tv; ram_dout = rd;
    endtask

    task automatic check_zero_outs(input string tag);
        check({tag, "_spi_ready"}, 32'(spi_ready), 32'h0);
        check({tag, "_hst_ready"}, 32'(hst_ready), 32'h0);
        check({tag, "_ram_rx_valid"}, 32'(ram_rx_valid), 32'h0);
        check({tag, "_ram_din"}, 32'(ram_din), 32'h0);
        check({tag, "_spi_dout"}, 32'(spi_dout), 32'h0);
        check({tag, "_spi_dout_valid"}, 32'(spi_dout_valid), 32'h0);
        check({tag, "_hst_dout"}, 32'(hst_dout), 32'h0);
        check({tag, "_hst_dout_valid"}, 32'(hst_dout_valid), 32'h0);
        check({tag, "_err_timeout"}, 32'(err_timeout), 32'h0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        //             sv  sd      hv  hd      tv  rd     esr ehr eret
        tbl[0]  = mk(1, 10'h005, 1, 10'h007, 0, 8'h00, 0, 0, 2'd0); // tie, SPI first
        tbl[1]  = mk(1, 10'h005, 1, 10'h007, 0, 8'h00, 1, 0, 2'd0); // 00 addr 5
        tbl[2]  = mk(1, 10'h1A5, 1, 10'h007, 0, 8'h00, 1, 0, 2'd0); // 01 data A5
        tbl[3]  = mk(1, 10'h00A, 1, 10'h007, 0, 8'h00, 0, 0, 2'd0); // tie, HST now
        tbl[4]  = mk(1, 10'h00A, 1, 10'h007, 0, 8'h00, 0, 1, 2'd0);
        tbl[5]  = mk(1, 10'h00A, 1, 10'h1C3, 0, 8'h00, 0, 1, 2'd0);
        tbl[6]  = mk(1, 10'h00A, 1, 10'h0FF, 0, 8'h00, 0, 0, 2'd0); // tie, SPI again
        tbl[7]  = mk(1, 10'h00A, 1, 10'h0FF, 0, 8'h00, 1, 0, 2'd0);
        tbl[8]  = mk(1, 10'h15A, 1, 10'h0FF, 0, 8'h00, 1, 0, 2'd0);
        tbl[9]  = mk(0, 10'h000, 1, 10'h205, 0, 8'h00, 0, 0, 2'd0); // HST read
        tbl[10] = mk(0, 10'h000, 1, 10'h205, 0, 8'h00, 0, 1, 2'd0); // 10 addr 5
        tbl[11] = mk(0, 10'h000, 1, 10'h300, 0, 8'h00, 0, 1, 2'd0); // 11
        tbl[12] = mk(1, 10'h011, 0, 10'h000, 0, 8'h00, 0, 0, 2'd0); // WAIT_RD, no grant
        tbl[13] = mk(1, 10'h011, 0, 10'h000, 1, 8'hA5, 0, 0, 2'd2); // return to HST
        tbl[14] = mk(1, 10'h011, 0, 10'h000, 0, 8'h00, 0, 0, 2'd0);
        tbl[15] = mk(1, 10'h3FF, 0, 10'h000, 0, 8'h00, 1, 0, 2'd0); // 11 as first cmd
        tbl[16] = mk(0, 10'h000, 0, 10'h000, 1, 8'h3C, 0, 0, 2'd1); // return to SPI
        tbl[17] = mk(0, 10'h000, 0, 10'h000, 1, 8'h77, 0, 0, 2'd0); // tx in IDLE ignored
        tbl[18] = mk(0, 10'h000, 0, 10'h000, 0, 8'h00, 0, 0, 2'd0);
        tbl[19] = mk(0, 10'h000, 1, 10'h155, 0, 8'h00, 0, 0, 2'd0);
        tbl[20] = mk(0, 10'h000, 1, 10'h155, 1, 8'h99, 0, 1, 2'd0); // 01 first; tx ignored
        tbl[21] = mk(0, 10'h000, 0, 10'h000, 0, 8'h00, 0, 0, 2'd0);

        // Reset: asserted between edges, outputs must clear at once.
        rst_n = 1'b1;
        drive(1'b0, 10'd0, 1'b0, 10'd0, 1'b0, 8'd0);
        #2 rst_n = 1'b0;
        #1 check_zero_outs("rst");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Table-driven section.
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].sv, tbl[i].sd, tbl[i].hv, tbl[i].hd, tbl[i].tv, tbl[i].rd);
            check($sformatf("v%0d_spi_ready", i), 32'(spi_ready), 32'(tbl[i].esr));
            check($sformatf("v%0d_hst_ready", i), 32'(hst_ready), 32'(tbl[i].ehr));
            if (tbl[i].sv && tbl[i].esr) ram_q.push_back(tbl[i].sd);
            if (tbl[i].hv && tbl[i].ehr) ram_q.push_back(tbl[i].hd);
            if (tbl[i].eret != 2'd0) ret_q.push_back({tbl[i].eret == 2'd2, tbl[i].rd});
            cyc();
        end
        check("hold_spi_dout", 32'(spi_dout), 32'h3C);
        check("hold_hst_dout", 32'(hst_dout), 32'hA5);

        // Lock held by SPI after an address command, with HST waiting.
        drive(1'b1, 10'h001, 1'b0, 10'h000, 1'b0, 8'h00);
        check("lk_idle_ready", {30'd0, spi_ready, hst_ready}, 32'h0);
        cyc();
        check("lk_spi_ready", 32'(spi_ready), 32'h1);
        ram_q.push_back(10'h001);
        cyc();
        drive(1'b0, 10'h000, 1'b1, 10'h00B, 1'b0, 8'h00);
`ifdef ARB_TIMEOUT_EN
        begin
            int err_at, err_cnt, grant_at;
            err_at = -1; err_cnt = 0; grant_at = -1;
            for (int k = 1; k <= 20; k++) begin
                cyc();
                if (err_timeout) begin
                    err_cnt++;
                    if (err_at < 0) err_at = k;
                end
                if (hst_ready) begin
                    grant_at = k;
                    break;
                end
            end
            check("tmo_err_cycle", 32'(err_at), 32'd8);
            check("tmo_err_count", 32'(err_cnt), 32'd1);
            check("tmo_hst_grant_cycle", 32'(grant_at), 32'd9);
        end
`else
        begin
            int spi_hi, hst_hi, err_hi;
            spi_hi = 0; hst_hi = 0; err_hi = 0;
            for (int k = 0; k < 110; k++) begin
                cyc();
                if (spi_ready) spi_hi++;
                if (hst_ready) hst_hi++;
                if (err_timeout) err_hi++;
            end
            check("lock_spi_held", 32'(spi_hi), 32'd110);
            check("lock_hst_blocked", 32'(hst_hi), 32'd0);
            check("lock_no_err", 32'(err_hi), 32'd0);
        end
        drive(1'b1, 10'h1EE, 1'b1, 10'h00B, 1'b0, 8'h00);
        check("rel_spi_ready", 32'(spi_ready), 32'h1);
        ram_q.push_back(10'h1EE);
        cyc();
        drive(1'b0, 10'h000, 1'b1, 10'h00B, 1'b0, 8'h00);
        check("rel_idle_ready", {30'd0, spi_ready, hst_ready}, 32'h0);
        cyc();
`endif
        // HST now owns the port: address then read-data command.
        check("own_hst_ready", 32'(hst_ready), 32'h1);
        ram_q.push_back(10'h00B);
        cyc();
        drive(1'b0, 10'h000, 1'b1, 10'h3AA, 1'b0, 8'h00);
        check("rd_hst_ready", 32'(hst_ready), 32'h1);
        ram_q.push_back(10'h3AA);
        cyc();

        // Reset while waiting for read data; nothing may be returned afterwards.
        drive(1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 8'h00);
        check("wr_rx_before_rst", 32'(ram_rx_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1 check_zero_outs("midrst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 8'h55);
        cyc();
        cyc();
        drive(1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 8'h00);
        check("post_rst_hst_dout", 32'(hst_dout), 32'h0);
        check("post_rst_ready", {30'd0, spi_ready, hst_ready}, 32'h0);
        check("sb_ram_drained", 32'(ram_q.size()), 32'd0);
        check("sb_ret_drained", 32'(ret_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter LOCK_TIMEOUT, default 64: cycles a lock is held without progress before forced release.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports spi_din  input  10, spi_valid  input  1, spi_ready  output  1: SPI-side command, {cmd[9:8], payload[7:0]}.
REQ-005 SHALL have ports spi_dout  output  8, spi_dout_valid  output  1: read data returned to SPI side.
REQ-006 SHALL have ports hst_din  input  10, hst_valid  input  1, hst_ready  output  1, hst_dout  output  8, hst_dout_valid  output  1: identical host-side requester.
REQ-007 SHALL have ports ram_din  output  10, ram_rx_valid  output  1, ram_dout  input  8, ram_tx_valid  input  1: single shared RAM port.
REQ-008 SHALL have port err_timeout  output  1: one-cycle pulse on forced lock release.

Function
REQ-009 Command codes: 00 write-address, 01 write-data, 10 read-address, 11 read-data.
REQ-010 States: IDLE, OWN_SPI, OWN_HST, WAIT_RD.
REQ-011 IDLE: if exactly one valid is high, next state is that requester's OWN state; if both, round-robin grants the requester not granted last; if neither, stay.
REQ-012 spi_ready = (state==OWN_SPI), hst_ready = (state==OWN_HST), both combinational from state only; never both high.
REQ-013 Handshake = valid & ready; on handshake, ram_din <= owner din and ram_rx_valid <= 1 at next edge (1-cycle latency); ram_rx_valid otherwise 0.
REQ-014 Accepted 00 or 10: remain in OWN state (lock held; back-to-back next command accepted the following cycle).
REQ-015 Accepted 01: next state IDLE.
REQ-016 Accepted 11: next state WAIT_RD; ready low while in WAIT_RD.
REQ-017 WAIT_RD: on ram_tx_valid, owner dout <= ram_dout, owner dout_valid <= 1 for exactly one cycle, next state IDLE; non-owner dout_valid stays 0.
REQ-018 ram_tx_valid outside WAIT_RD SHALL be ignored (no dout_valid pulse).
REQ-019 A data command (01/11) as first command of a grant SHALL be accepted and forwarded; no lock retained beyond REQ-015/016.
REQ-020 Owner identity for WAIT_RD return SHALL be recorded at 11 acceptance; last-granted pointer updates on every IDLE->OWN transition.
REQ-021 spi_dout/hst_dout SHALL hold last returned value until next return.

Reset
REQ-022 On rst_n low, immediately: state IDLE, last-granted = HST (SPI wins first tie), all ready/valid/err outputs 0, ram_din 0, dout regs 0, timeout counter 0.
REQ-023 Reset mid-transaction SHALL abandon the lock; no pending read return delivered after deassertion.

Configuration
REQ-024 Macro ARB_TIMEOUT_EN: when defined, counter increments each cycle in OWN_x without handshake or in WAIT_RD, clears on handshake or state change; reaching LOCK_TIMEOUT forces IDLE and pulses err_timeout one cycle.
REQ-025 Without ARB_TIMEOUT_EN: no counter, lock held indefinitely, err_timeout tied 0.

Verification
REQ-026 Both valid in IDLE after reset, spi_din=0x0_05 (00,addr 5), then 01 data 0xA5 -> OWN_SPI granted first; ram_din 0x005 then 0x1A5, one cycle after each handshake; then IDLE.
REQ-027 Both valid continuously, each issuing 00/01 pairs -> grants alternate SPI, HST, SPI; hst_ready never high during an SPI lock.
REQ-028 HST issues 10 addr 5 then 11; ram_tx_valid with ram_dout=0xA5 two cycles later -> hst_dout=0xA5, hst_dout_valid one-cycle pulse, spi_dout_valid 0.
REQ-029 ram_tx_valid pulse while IDLE -> no dout_valid on either side.
REQ-030 ARB_TIMEOUT_EN, LOCK_TIMEOUT=8, SPI sends 00 then drops valid -> forced IDLE 8 cycles later, err_timeout pulse, pending HST granted next; without macro, lock held for 100+ cycles.
REQ-031 rst_n low during WAIT_RD -> outputs 0 asynchronously; post-reset ram_tx_valid produces no dout_valid.
